id_stage: RTL and testbench

- Decode stage of the RISC-V integer pipeline, directly upstream of the ALU.
- Accepts fetched instructions over a valid/ready handshake and reads the register file.
- Produces ALU control and operands, din_0/din_1, in a registered pipeline slot for the execute stage.
- Tracks in-flight destination registers in a scoreboard and stalls on RAW/WAW hazards, with a writeback bypass.

---
 rtl/rv_pkg.sv | 24 ++
 rtl/id_scoreboard.sv | 29 ++
 rtl/id_stage.sv | 136 +++++++++++++
 tb/tb_id_stage.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared RV32I decode constants and ALU control encoding
package rv_pkg;

    localparam int REG_DATA_WIDTH_DEFAULT = 32;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b1000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_SRA  = 4'b1101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111
    } alu_ctrl_t;

endpackage

// File: rtl/id_scoreboard.sv
// rtl/id_scoreboard.sv - busy bit per architectural register, set wins over clear
module id_scoreboard #(
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                              clk,
    input  logic                              nreset,
    input  logic                              set_en,
    input  logic [REG_ADDR_WIDTH-1:0]         set_addr,
    input  logic                              clr_en,
    input  logic [REG_ADDR_WIDTH-1:0]         clr_addr,
    output logic [(1<<REG_ADDR_WIDTH)-1:0]    busy
);

    // x0 is never written, so its bit only ever holds the reset value
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            busy <= '0;
        end else begin
            for (int i = 1; i < (1 << REG_ADDR_WIDTH); i++) begin
                if (set_en && set_addr == REG_ADDR_WIDTH'(i)) begin
                    busy[i] <= 1'b1;
                end else if (clr_en && clr_addr == REG_ADDR_WIDTH'(i)) begin
                    busy[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/id_stage.sv
// rtl/id_stage.sv - RV32I decode stage with hazard scoreboard and writeback bypass
module id_stage
    import rv_pkg::*;
#(
    parameter int REG_DATA_WIDTH = REG_DATA_WIDTH_DEFAULT,
    parameter int CTRL_WIDTH     = 4,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      nreset,
    input  logic                      if_valid,
    output logic                      if_ready,
    input  logic [REG_DATA_WIDTH-1:0] if_pc,
    input  logic [31:0]               if_inst,
    output logic [REG_ADDR_WIDTH-1:0] rs1_addr,
    output logic [REG_ADDR_WIDTH-1:0] rs2_addr,
    input  logic [REG_DATA_WIDTH-1:0] rs1_data,
    input  logic [REG_DATA_WIDTH-1:0] rs2_data,
    input  logic                      wb_en,
    input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
    input  logic [REG_DATA_WIDTH-1:0] wb_data,
    output logic                      ex_valid,
    input  logic                      ex_ready,
    output logic [CTRL_WIDTH-1:0]     ex_ctrl,
    output logic [REG_DATA_WIDTH-1:0] ex_din_0,
    output logic [REG_DATA_WIDTH-1:0] ex_din_1,
    output logic [REG_ADDR_WIDTH-1:0] ex_rd,
    output logic                      ex_wb_en,
    output logic                      ex_illegal
);

    logic [6:0]                          opcode;
    logic [2:0]                          funct3;
    logic [REG_ADDR_WIDTH-1:0]           rd;
    logic                                byp_1, byp_2, wb_hits_rd;
    logic [REG_DATA_WIDTH-1:0]           rs1_val, rs2_val;
    logic                                use_rs1, use_rs2, illegal, wr_en;
    logic [CTRL_WIDTH-1:0]               ctrl;
    logic [REG_DATA_WIDTH-1:0]           op_0, op_1;
    logic [(1<<REG_ADDR_WIDTH)-1:0]      busy;
    logic                                hazard, slot_free, xfer;

    assign opcode   = if_inst[6:0];
    assign funct3   = if_inst[14:12];
    assign rd       = if_inst[11:7];
    assign rs1_addr = if_inst[19:15];
    assign rs2_addr = if_inst[24:20];

    assign byp_1      = wb_en && wb_rd == rs1_addr && rs1_addr != '0;
    assign byp_2      = wb_en && wb_rd == rs2_addr && rs2_addr != '0;
    assign wb_hits_rd = wb_en && wb_rd == rd;
    assign rs1_val    = (rs1_addr == '0) ? '0 : (byp_1 ? wb_data : rs1_data);
    assign rs2_val    = (rs2_addr == '0) ? '0 : (byp_2 ? wb_data : rs2_data);

    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        illegal = 1'b0;
        ctrl    = CTRL_WIDTH'(ALU_ADD);
        op_0    = '0;
        op_1    = '0;
        case (opcode)
            OP: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                ctrl    = CTRL_WIDTH'({if_inst[30], funct3});
                op_0    = rs1_val;
                op_1    = rs2_val;
            end
            OP_IMM: begin
                use_rs1 = 1'b1;
                op_0    = rs1_val;
                // shifts carry a 5-bit shamt; only srai borrows funct7[5] for the ctrl msb
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    ctrl = CTRL_WIDTH'({funct3 == 3'b101 && if_inst[30], funct3});
                    op_1 = REG_DATA_WIDTH'(if_inst[24:20]);
                end else begin
                    ctrl = CTRL_WIDTH'({1'b0, funct3});
                    op_1 = {{(REG_DATA_WIDTH-12){if_inst[31]}}, if_inst[31:20]};
                end
            end
            LUI: begin
                op_1 = {{(REG_DATA_WIDTH-31){if_inst[31]}}, if_inst[30:12], 12'b0};
            end
            AUIPC: begin
                op_0 = if_pc;
                op_1 = {{(REG_DATA_WIDTH-31){if_inst[31]}}, if_inst[30:12], 12'b0};
            end
            default: illegal = 1'b1;
        endcase
    end

    assign wr_en = !illegal && rd != '0;

    assign hazard = if_valid &&
                    ((use_rs1 && busy[rs1_addr] && !byp_1) ||
                     (use_rs2 && busy[rs2_addr] && !byp_2) ||
                     (wr_en && busy[rd] && !wb_hits_rd));

    assign slot_free = !ex_valid || ex_ready;
    assign if_ready  = slot_free && !hazard;
    assign xfer      = if_valid && if_ready;

    id_scoreboard #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_scoreboard (
        .clk      (clk),
        .nreset   (nreset),
        .set_en   (xfer && wr_en),
        .set_addr (rd),
        .clr_en   (wb_en),
        .clr_addr (wb_rd),
        .busy     (busy)
    );

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            ex_valid   <= 1'b0;
            ex_ctrl    <= '0;
            ex_din_0   <= '0;
            ex_din_1   <= '0;
            ex_rd      <= '0;
            ex_wb_en   <= 1'b0;
            ex_illegal <= 1'b0;
        end else if (xfer) begin
            ex_valid   <= 1'b1;
            ex_ctrl    <= ctrl;
            ex_din_0   <= op_0;
            ex_din_1   <= op_1;
            ex_rd      <= rd;
            ex_wb_en   <= wr_en;
            ex_illegal <= illegal;
        end else if (ex_ready) begin
            ex_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - randomized decode-stage bench against an in-flight list model
module tb_id_stage;

    logic        clk = 1'b0;
    logic        nreset;
    logic        if_valid, if_ready;
    logic [31:0] if_pc, if_inst;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        ex_valid, ex_ready;
    logic [3:0]  ex_ctrl;
    logic [31:0] ex_din_0, ex_din_1;
    logic [4:0]  ex_rd;
    logic        ex_wb_en, ex_illegal;

    always #5 clk = ~clk;

    id_stage dut (
        .clk(clk), .nreset(nreset),
        .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_inst(if_inst),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_ctrl(ex_ctrl),
        .ex_din_0(ex_din_0), .ex_din_1(ex_din_1), .ex_rd(ex_rd),
        .ex_wb_en(ex_wb_en), .ex_illegal(ex_illegal)
    );

    typedef struct packed {
        logic [3:0]  ctrl;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [4:0]  rd;
        logic        wb;
        logic        ill;
    } slot_t;

    logic [31:0] rf [32];
    slot_t       exp_s;
    bit          exp_v;
    bit          last_taken;
    int          wbq[$];
    int          vectors = 0;
    int          miscompares = 0;

    assign rs1_data = rf[rs1_addr];
    assign rs2_data = rf[rs2_addr];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit wb_hit(input logic [4:0] r);
        return wb_en && wb_rd == r && r != 5'd0;
    endfunction

    function automatic logic [31:0] opval(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
        if (wb_hit(r)) return wb_data;
        return rf[r];
    endfunction

    // a register is in flight while its writer sits in the slot or awaits writeback
    function automatic bit in_flight(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        if (exp_v && exp_s.wb && exp_s.rd == r) return 1'b1;
        foreach (wbq[i]) if (wbq[i] == int'(r)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic slot_t model_decode(input logic [31:0] inst, input logic [31:0] pc,
                                           output bit u1, output bit u2);
        slot_t      s;
        logic [2:0] f3;
        f3 = inst[14:12];
        s = '0;
        s.rd = inst[11:7];
        u1 = 1'b0;
        u2 = 1'b0;
        case (inst[6:0])
            7'h33: begin
                u1 = 1'b1; u2 = 1'b1;
                s.ctrl = {inst[30], f3};
                s.d0 = opval(inst[19:15]);
                s.d1 = opval(inst[24:20]);
            end
            7'h13: begin
                u1 = 1'b1;
                s.d0 = opval(inst[19:15]);
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    s.d1 = (inst >> 20) & 32'd31;
                    s.ctrl = {(f3 == 3'd5) ? inst[30] : 1'b0, f3};
                end else begin
                    s.d1 = $signed(inst) >>> 20;
                    s.ctrl = {1'b0, f3};
                end
            end
            7'h37: s.d1 = inst & 32'hFFFFF000;
            7'h17: begin s.d0 = pc; s.d1 = inst & 32'hFFFFF000; end
            default: s.ill = 1'b1;
        endcase
        s.wb = !s.ill && s.rd != 5'd0;
        return s;
    endfunction

    task automatic setin(input bit v, input logic [31:0] inst, input logic [31:0] pc, input bit rdy,
                         input bit we, input logic [4:0] wr, input logic [31:0] wd);
        if_valid = v; if_inst = inst; if_pc = pc; ex_ready = rdy;
        wb_en = we; wb_rd = wr; wb_data = wd;
    endtask

    task automatic check_slot();
        chk("ex_valid", ex_valid, exp_v);
        if (exp_v) begin
            chk("ex_ctrl", ex_ctrl, exp_s.ctrl);
            chk("ex_din_0", ex_din_0, exp_s.d0);
            chk("ex_din_1", ex_din_1, exp_s.d1);
            chk("ex_rd", ex_rd, exp_s.rd);
            chk("ex_wb_en", ex_wb_en, exp_s.wb);
            chk("ex_illegal", ex_illegal, exp_s.ill);
        end
    endtask

    // entered just after a negedge with inputs applied; returns at the next negedge
    task automatic step(input int want_rdy);
        slot_t nd;
        bit    u1, u2, hz, rdy, xfer;
        #1;
        nd = model_decode(if_inst, if_pc, u1, u2);
        hz = if_valid && ((u1 && in_flight(if_inst[19:15]) && !wb_hit(if_inst[19:15])) ||
                          (u2 && in_flight(if_inst[24:20]) && !wb_hit(if_inst[24:20])) ||
                          (nd.wb && in_flight(nd.rd) && !(wb_en && wb_rd == nd.rd)));
        rdy = (!exp_v || ex_ready) && !hz;
        chk("if_ready", if_ready, rdy);
        if (want_rdy >= 0) chk("if_ready_lit", if_ready, want_rdy[0]);
        chk("rs1_addr", rs1_addr, if_inst[19:15]);
        chk("rs2_addr", rs2_addr, if_inst[24:20]);
        xfer = if_valid && rdy;
        @(posedge clk);
        #1;
        if (wb_en) begin
            rf[wb_rd] = wb_data;
            for (int i = 0; i < wbq.size(); i++)
                if (wbq[i] == int'(wb_rd)) begin wbq.delete(i); break; end
        end
        if (exp_v && ex_ready && exp_s.wb) wbq.push_back(int'(exp_s.rd));
        if (xfer) begin exp_s = nd; exp_v = 1'b1; end
        else if (ex_ready) exp_v = 1'b0;
        last_taken = xfer;
        @(negedge clk);
        check_slot();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, ex_valid, 1'b0);
        chk({tag, "_ctrl"}, ex_ctrl, 4'd0);
        chk({tag, "_din_0"}, ex_din_0, 32'd0);
        chk({tag, "_din_1"}, ex_din_1, 32'd0);
        chk({tag, "_rd_wb_ill"}, {ex_rd, ex_wb_en, ex_illegal}, 7'd0);
    endtask

    task automatic do_reset();
        if_valid = 1'b0; wb_en = 1'b0;
        #2 nreset = 1'b0;
        #1 check_reset_outputs("mid_reset");
        @(posedge clk);
        @(negedge clk);
        nreset = 1'b1;
        exp_v = 1'b0;
        wbq.delete();
        last_taken = 1'b1;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        logic [2:0]  f3;
        logic [4:0]  rd, s1, s2;
        r = $urandom;
        f3 = r[14:12];
        rd = 5'($urandom_range(0, 7));
        s1 = 5'($urandom_range(0, 7));
        s2 = 5'($urandom_range(0, 7));
        case ($urandom % 6)
            0: return {((f3 == 3'd0 || f3 == 3'd5) && r[0]) ? 7'h20 : 7'h00, s2, s1, f3, rd, 7'h33};
            1, 2: begin
                if (f3 == 3'd1) return {7'h00, r[24:20], s1, f3, rd, 7'h13};
                if (f3 == 3'd5) return {r[1] ? 7'h20 : 7'h00, r[24:20], s1, f3, rd, 7'h13};
                return {r[31:20], s1, f3, rd, 7'h13};
            end
            3: return {r[31:12], rd, 7'h37};
            4: return {r[31:12], rd, 7'h17};
            default: begin
                if (r[2]) return 32'hFFFFFFFF;
                if (r[6:0] == 7'h33 || r[6:0] == 7'h13 || r[6:0] == 7'h37 || r[6:0] == 7'h17)
                    r[6] = ~r[6];
                return r;
            end
        endcase
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        rf[0] = 32'hDEADBEEF;
        nreset = 1'b0;
        exp_v = 1'b0;
        last_taken = 1'b1;
        setin(0, 32'h0, 32'h0, 1, 0, 5'd0, 32'h0);
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        nreset = 1'b1;

        setin(1, 32'h00500093, 32'h0, 1, 0, 5'd0, 32'h0); step(1);
        chk("addi_valid", ex_valid, 1'b1);
        chk("addi_ctrl", ex_ctrl, 4'b0000);
        chk("addi_din", {ex_din_0, ex_din_1}, {32'd0, 32'd5});
        chk("addi_rd_wb", {ex_rd, ex_wb_en}, {5'd1, 1'b1});

        rf[1] = 32'd99;
        setin(1, 32'h00108233, 32'h0, 1, 0, 5'd0, 32'h0); step(0);
        step(0);
        setin(1, 32'h00108233, 32'h0, 1, 1, 5'd1, 32'd5); step(1);
        chk("raw_bypass", {ex_din_0, ex_din_1, ex_rd}, {32'd5, 32'd5, 5'd4});
        setin(1, 32'h00108313, 32'h0, 1, 0, 5'd0, 32'h0); step(1);

        rf[1] = 32'd10; rf[2] = 32'd3;
        setin(1, 32'h402081B3, 32'h0, 1, 0, 5'd0, 32'h0); step(1);
        chk("sub_ctrl", ex_ctrl, 4'b1000);
        chk("sub_din", {ex_din_0, ex_din_1}, {32'd10, 32'd3});
        setin(1, 32'h40335293, 32'h0, 1, 1, 5'd6, 32'h55); step(1);
        chk("srai", {ex_ctrl, ex_din_0, ex_din_1}, {4'b1101, 32'h55, 32'd3});
        setin(1, 32'h123453B7, 32'h0, 1, 0, 5'd0, 32'h0); step(1);
        chk("lui", {ex_din_0, ex_din_1}, {32'd0, 32'h12345000});
        setin(1, 32'h00001417, 32'h100, 1, 0, 5'd0, 32'h0); step(1);
        chk("auipc", {ex_din_0, ex_din_1}, {32'h100, 32'h1000});

        setin(1, 32'h00700493, 32'h0, 1, 0, 5'd0, 32'h0); step(1);
        setin(1, 32'hFFFFFFFF, 32'h0, 0, 0, 5'd0, 32'h0);
        repeat (3) begin
            step(0);
            chk("stall_hold", {ex_valid, ex_din_1, ex_rd}, {1'b1, 32'd7, 5'd9});
        end
        ex_ready = 1'b1; step(1);
        chk("illegal", {ex_valid, ex_illegal, ex_wb_en, ex_ctrl}, {1'b1, 1'b1, 1'b0, 4'd0});
        chk("illegal_din", {ex_din_0, ex_din_1}, 64'd0);
        setin(1, 32'h00100513, 32'h0, 1, 0, 5'd0, 32'h0); step(1);
        setin(0, 32'h0, 32'h0, 0, 0, 5'd0, 32'h0); step(-1);
        do_reset();
        setin(1, 32'h00A505B3, 32'h0, 1, 0, 5'd0, 32'h0); step(1);

        for (int n = 0; n < 3000; n++) begin
            if ($urandom % 500 == 0) do_reset();
            if (!(if_valid && !last_taken)) begin
                if_valid = ($urandom % 4) != 0;
                if_inst  = rand_inst();
                if_pc    = $urandom & 32'hFFFFFFFC;
            end
            ex_ready = ($urandom % 10) < 7;
            if (wbq.size() > 0 && ($urandom % 3) != 0) begin
                wb_en   = 1'b1;
                wb_rd   = 5'(wbq[$urandom % wbq.size()]);
                wb_data = $urandom;
            end else begin
                wb_en   = 1'b0;
                wb_rd   = 5'($urandom);
                wb_data = $urandom;
            end
            step(-1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
